// File: rtl/nios2_system_pio_pkg.sv
// Shared definitions for the Nios II output PIO: register map and pulse FSM states.
package nios2_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PULSE    = 3'd2;
    localparam logic [2:0] ADDR_IRQ      = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/nios2_system_pio_pulse_timer.sv
// Retriggerable one-shot: holds pulse_mask for PULSE_CYCLES clocks after the last
// nonzero start; done strobes (combinationally) on the cycle the FSM returns to IDLE.
module nios2_system_pio_pulse_timer
    import nios2_system_pio_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int PULSE_CYCLES = 50000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bits,
    output logic [WIDTH-1:0] pulse_mask,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_CYCLES - 1);

    pulse_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             trigger;

    // A start with no bits set is treated as no start at all.
    assign trigger = start && (bits != '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mask_d  = mask_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = ACTIVE;
                    count_d = RELOAD;
                    mask_d  = bits;
                end
            end
            ACTIVE: begin
                if (trigger) begin
                    count_d = RELOAD;
                    mask_d  = mask_q | bits;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    mask_d  = '0;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mask_q  <= mask_d;
        end
    end

    assign pulse_mask = mask_q;
    assign busy       = (state_q == ACTIVE);

endmodule

// File: rtl/nios2_system_pio_ledout.sv
// Avalon-MM output PIO with set/clear registers and a one-shot inversion pulse.
// Optional completion interrupt on address 3 when PIO_PULSE_IRQ_EN is defined.
module nios2_system_pio_ledout
    import nios2_system_pio_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 50000,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
`ifdef PIO_PULSE_IRQ_EN
    output logic             irq,
`endif
    output logic             pulse_busy
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] pulse_mask;
    logic             pulse_done;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_wdata_upper
        logic unused_wdata_upper;
        assign unused_wdata_upper = ^writedata[31:WIDTH];
    end

    nios2_system_pio_pulse_timer #(
        .WIDTH       (WIDTH),
        .PULSE_CYCLES(PULSE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_pulse_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (wr && (address == ADDR_PULSE)),
        .bits      (wdata),
        .pulse_mask(pulse_mask),
        .busy      (pulse_busy),
        .done      (pulse_done)
    );

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = wdata;
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       data_d = data_q;
            endcase
        end
    end

`ifdef PIO_PULSE_IRQ_EN
    logic irq_q, irq_d;

    // Software acknowledge beats a completion landing in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (wr && (address == ADDR_IRQ)) irq_d = 1'b0;
        else if (pulse_done)             irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    logic unused_pulse_done;
    assign unused_pulse_done = pulse_done;
`endif

    // Read path samples the selected register every cycle, chipselect or not.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA:  readdata_d = 32'(data_q);
            ADDR_PULSE: readdata_d = 32'(pulse_mask);
`ifdef PIO_PULSE_IRQ_EN
            ADDR_IRQ:   readdata_d = {31'd0, irq_q};
`endif
            default:    readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q ^ pulse_mask;

endmodule

// File: tb/tb_nios2_system_pio_ledout.sv
// Bench for nios2_system_pio_ledout: directed plan plus random bus traffic,
// compared every cycle against a remaining-cycles model of the pulse behaviour.
module tb_nios2_system_pio_ledout;

  localparam int         WIDTH = 4;
  localparam logic [3:0] RST_V = 4'b0101;
  localparam int         PCYC  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        pulse_busy;
`ifdef PIO_PULSE_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  nios2_system_pio_ledout #(
    .WIDTH(WIDTH), .RESET_VALUE(RST_V), .PULSE_CYCLES(PCYC), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port),
`ifdef PIO_PULSE_IRQ_EN
    .irq(irq),
`endif
    .pulse_busy(pulse_busy)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: data value, mask being inverted, cycles of inversion left.
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  int          m_rem;
  logic        m_irq;
  logic [31:0] exp_q[$];

  function automatic void model_reset();
    m_data = RST_V;
    m_mask = 4'd0;
    m_rem  = 0;
    m_irq  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_edge(input logic [2:0] a, input logic cs, input logic wn,
                                     input logic [31:0] wd);
    logic       w;
    logic [3:0] b;
    logic       fin;
    logic [31:0] rd;
    w = cs && !wn;
    b = wd[3:0];
    fin = 1'b0;
    rd = 32'd0;
    if (a == 3'd0) rd = {28'd0, m_data};
    if (a == 3'd2) rd = {28'd0, m_mask};
`ifdef PIO_PULSE_IRQ_EN
    if (a == 3'd3) rd = {31'd0, m_irq};
`endif
    exp_q.push_back(rd);
    if (w && a == 3'd0) m_data = b;
    if (w && a == 3'd4) m_data = m_data | b;
    if (w && a == 3'd5) m_data = m_data & ~b;
    if (w && a == 3'd2 && b != 4'd0) begin
      m_mask = (m_rem > 0) ? (m_mask | b) : b;
      m_rem  = PCYC;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_mask = 4'd0;
        fin = 1'b1;
      end
    end
    if (w && a == 3'd3) m_irq = 1'b0;
    else if (fin)       m_irq = 1'b1;
  endfunction

  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a;
    chipselect = cs;
    write_n = wn;
    writedata = wd;
    @(posedge clk);
    model_edge(a, cs, wn, wd);
    #1;
    check("out_port", {28'd0, out_port}, {28'd0, m_data ^ m_mask});
    check("pulse_busy", {31'd0, pulse_busy}, {31'd0, (m_rem > 0)});
    check("readdata", readdata, exp_q.pop_front());
`ifdef PIO_PULSE_IRQ_EN
    check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  endtask

  task automatic idle(input logic [2:0] a);
    step(a, 1'b0, 1'b1, 32'd0);
  endtask

  int busy_cnt;

  initial begin
    model_reset();
    #23;
    check("rst_out_port", {28'd0, out_port}, {28'd0, RST_V});
    check("rst_busy", {31'd0, pulse_busy}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    #3;

    idle(3'd0);
    check("read_data_after_reset", readdata, 32'h5);

    step(3'd4, 1'b1, 1'b0, 32'hA);
    check("outset_out", {28'd0, out_port}, 32'hF);
    step(3'd5, 1'b1, 1'b0, 32'h1);
    check("outclear_out", {28'd0, out_port}, 32'hE);
    idle(3'd0);
    check("read_data_E", readdata, 32'hE);

    step(3'd0, 1'b1, 1'b0, 32'h0);
    busy_cnt = 0;
    step(3'd2, 1'b1, 1'b0, 32'h3);
    check("pulse_out", {28'd0, out_port}, 32'h3);
    if (pulse_busy) busy_cnt++;
    for (int i = 0; i < 10; i++) begin
      idle(3'd2);
      if (i == 2) check("read_pulse_mid", readdata, 32'h3);
      if (pulse_busy) busy_cnt++;
    end
    check("pulse_busy_cycles", busy_cnt, 32'd8);
    check("pulse_end_out", {28'd0, out_port}, 32'h0);

    busy_cnt = 0;
    step(3'd2, 1'b1, 1'b0, 32'h1);
    if (pulse_busy) busy_cnt++;
    for (int i = 0; i < 4; i++) begin
      idle(3'd0);
      if (pulse_busy) busy_cnt++;
    end
    step(3'd2, 1'b1, 1'b0, 32'h4);
    check("retrig_out", {28'd0, out_port}, 32'h5);
    if (pulse_busy) busy_cnt++;
    for (int i = 0; i < 12; i++) begin
      idle(3'd2);
      if (pulse_busy) busy_cnt++;
    end
    check("retrig_busy_cycles", busy_cnt, 32'd13);

    step(3'd2, 1'b1, 1'b0, 32'h0);
    check("zero_pulse_busy", {31'd0, pulse_busy}, 32'd0);

`ifdef PIO_PULSE_IRQ_EN
    step(3'd2, 1'b1, 1'b0, 32'h1);
    for (int i = 0; i < 9; i++) idle(3'd3);
    check("irq_set", {31'd0, irq}, 32'd1);
    idle(3'd3);
    check("read_irq", readdata, 32'h1);
    step(3'd3, 1'b1, 1'b0, 32'h0);
    check("irq_cleared", {31'd0, irq}, 32'd0);
`endif

    step(3'd2, 1'b1, 1'b0, 32'hF);
    for (int i = 0; i < 3; i++) idle(3'd2);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_out_port", {28'd0, out_port}, {28'd0, RST_V});
    check("midrst_busy", {31'd0, pulse_busy}, 32'd0);
    check("midrst_readdata", readdata, 32'd0);
    #12;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) idle(3'd2);

    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic        cs;
      logic        wn;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      cs = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 9) < 7);
      wd = $urandom;
      step(a, cs, wn, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
